// File: rtl/code_entry_pkg.sv
// Shared state encoding for the code-entry lock; the 3-bit values drive LEDs/debug directly.
package code_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_UNLOCK  = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus run-length debouncer; level follows the input after DEBOUNCE_CYCLES equal samples.
// settled rises with the first accepted level after reset, so a switch held through reset is not seen as an edge.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic settled
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] RUN_DONE = DW'(DEBOUNCE_CYCLES);

  logic          sync1, sync2, sync_prev;
  logic [DW-1:0] run_q, run_nxt;

  always_comb begin
    run_nxt = run_q;
    if (sync2 != sync_prev) begin
      run_nxt = DW'(1);
    end else if (run_q != RUN_DONE) begin
      run_nxt = run_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      run_q     <= '0;
      level     <= 1'b0;
      settled   <= 1'b0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      sync_prev <= sync2;
      run_q     <= run_nxt;
      if (run_nxt == RUN_DONE) begin
        level   <= sync2;
        settled <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/code_entry_ctrl.sv
// Serial code-entry lock: debounced strobe/data switches shift bits in, full code is compared once,
// repeated mismatches lock the entry out for a fixed time. Bit events act one cycle after the debounced rise.
module code_entry_ctrl
  import code_entry_pkg::*;
#(
  parameter int CODE_LEN        = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter int MAX_FAIL        = 3,
  parameter int LOCKOUT_CYCLES  = 1000000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_strobe,
  input  logic                          sw_data,
  input  logic                          clear,
  input  logic [CODE_LEN-1:0]           code_ref,
  output logic [CODE_LEN-1:0]           recorded,
  output logic [$clog2(CODE_LEN+1)-1:0] bit_count,
  output logic                          unlocked,
  output logic                          fail,
  output logic                          locked_out,
  output logic [2:0]                    state
);

  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CODE_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);

  state_e              state_q, state_nxt;
  logic [CODE_LEN-1:0] rec_q, rec_nxt;
  logic [CW-1:0]       cnt_q, cnt_nxt;
  logic [FW-1:0]       fcnt_q, fcnt_nxt;
  logic [TW-1:0]       itmr_q, itmr_nxt;
  logic [LW-1:0]       ltmr_q, ltmr_nxt;
  logic                fail_q, fail_nxt;
  logic                stb_lvl, stb_ok, dat_lvl, dat_ok;
  logic                stb_prev, stb_armed;
  logic                bit_evt, bit_val;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_strobe (
    .clk(clk), .rst_n(rst_n), .raw(sw_strobe), .level(stb_lvl), .settled(stb_ok)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_data (
    .clk(clk), .rst_n(rst_n), .raw(sw_data), .level(dat_lvl), .settled(dat_ok)
  );

  // Only a rise after the strobe has first settled counts; a level accepted at power-up is not an edge.
  assign bit_evt = stb_lvl & ~stb_prev & stb_armed;
  assign bit_val = dat_lvl & dat_ok;

  always_comb begin
    state_nxt = state_q;
    rec_nxt   = rec_q;
    cnt_nxt   = cnt_q;
    fcnt_nxt  = fcnt_q;
    itmr_nxt  = itmr_q;
    ltmr_nxt  = ltmr_q;
    fail_nxt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          rec_nxt = '0;
          cnt_nxt = '0;
        end else if (bit_evt) begin
          rec_nxt   = {rec_q[CODE_LEN-2:0], bit_val};
          cnt_nxt   = CW'(1);
          itmr_nxt  = '0;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (clear) begin
          rec_nxt   = '0;
          cnt_nxt   = '0;
          itmr_nxt  = '0;
          state_nxt = ST_IDLE;
        end else if (bit_evt) begin
          rec_nxt  = {rec_q[CODE_LEN-2:0], bit_val};
          cnt_nxt  = cnt_q + CW'(1);
          itmr_nxt = '0;
          if (cnt_q == CNT_LAST) state_nxt = ST_CHECK;
        end else if (itmr_q >= TMO_LAST) begin
          rec_nxt   = '0;
          cnt_nxt   = '0;
          itmr_nxt  = '0;
          state_nxt = ST_IDLE;
        end else if (itmr_q != '1) begin
          itmr_nxt = itmr_q + TW'(1);
        end
      end
      ST_CHECK: begin
        if (rec_q == code_ref) begin
          fcnt_nxt  = '0;
          state_nxt = ST_UNLOCK;
        end else begin
          fail_nxt = 1'b1;
          rec_nxt  = '0;
          cnt_nxt  = '0;
          ltmr_nxt = '0;
          if (fcnt_q != '1) fcnt_nxt = fcnt_q + FW'(1);
          state_nxt = (fcnt_q >= FAIL_LAST) ? ST_LOCKOUT : ST_IDLE;
        end
      end
      ST_UNLOCK: begin
        if (clear) begin
          rec_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (ltmr_q >= LCK_LAST) begin
          fcnt_nxt  = '0;
          ltmr_nxt  = '0;
          state_nxt = ST_IDLE;
        end else if (ltmr_q != '1) begin
          ltmr_nxt = ltmr_q + LW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rec_q     <= '0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      itmr_q    <= '0;
      ltmr_q    <= '0;
      fail_q    <= 1'b0;
      stb_prev  <= 1'b0;
      stb_armed <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rec_q     <= rec_nxt;
      cnt_q     <= cnt_nxt;
      fcnt_q    <= fcnt_nxt;
      itmr_q    <= itmr_nxt;
      ltmr_q    <= ltmr_nxt;
      fail_q    <= fail_nxt;
      stb_prev  <= stb_lvl;
      stb_armed <= stb_ok;
    end
  end

  assign recorded   = rec_q;
  assign bit_count  = cnt_q;
  assign fail       = fail_q;
  assign unlocked   = (state_q == ST_UNLOCK);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign state      = state_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl with a queue-based behavioural model checked every cycle.
module tb_code_entry_ctrl;
  import code_entry_pkg::*;

  localparam int CL   = 4;
  localparam int DEB  = 4;
  localparam int TMO  = 50;
  localparam int MAXF = 3;
  localparam int LCK  = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_strobe = 1'b0;
  logic          sw_data = 1'b0;
  logic          clear = 1'b0;
  logic [CL-1:0] code_ref = 4'b1011;
  logic [CL-1:0] recorded;
  logic [2:0]    bit_count;
  logic          unlocked, fail, locked_out;
  logic [2:0]    state;

  code_entry_ctrl #(
    .CODE_LEN(CL), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO),
    .MAX_FAIL(MAXF), .LOCKOUT_CYCLES(LCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_strobe(sw_strobe), .sw_data(sw_data), .clear(clear),
    .code_ref(code_ref), .recorded(recorded), .bit_count(bit_count), .unlocked(unlocked),
    .fail(fail), .locked_out(locked_out), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fail_seen = 0;
  int lock_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef logic lq_t[$];

  function automatic bit all_same(input lq_t h);
    if (h.size() < DEB) return 1'b0;
    foreach (h[i]) if (h[i] !== h[0]) return 1'b0;
    return 1'b1;
  endfunction

  state_e        m_st = ST_IDLE;
  logic [CL-1:0] m_rec = '0;
  int            m_cnt = 0, m_fails = 0, m_since = 0, m_lock = 0;
  logic          m_fail = 1'b0;
  lq_t           pipe_s, pipe_d, hist_s, hist_d;
  logic          lv_s = 0, lv_d = 0, ok_s = 0, ok_d = 0, lv_s_prev = 0, ok_s_prev = 0;
  logic          m_pend;

  assign m_pend = lv_s & ~lv_s_prev & ok_s_prev;

  always @(posedge clk) begin
    logic ev, bv, smp;
    if (!rst_n) begin
      m_st = ST_IDLE; m_rec = '0; m_cnt = 0; m_fails = 0; m_since = 0; m_lock = 0; m_fail = 0;
      pipe_s = '{1'b0, 1'b0}; pipe_d = '{1'b0, 1'b0};
      hist_s = {}; hist_d = {};
      lv_s = 0; lv_d = 0; ok_s = 0; ok_d = 0; lv_s_prev = 0; ok_s_prev = 0;
    end else begin
      ev = lv_s && !lv_s_prev && ok_s_prev;
      bv = lv_d && ok_d;
      m_fail = 0;
      case (m_st)
        ST_IDLE: if (!clear && ev) begin
          m_rec = {m_rec[CL-2:0], bv}; m_cnt = 1; m_since = 0; m_st = ST_COLLECT;
        end
        ST_COLLECT: begin
          if (clear) begin
            m_rec = '0; m_cnt = 0; m_st = ST_IDLE;
          end else if (ev) begin
            m_rec = {m_rec[CL-2:0], bv}; m_cnt++; m_since = 0;
            if (m_cnt == CL) m_st = ST_CHECK;
          end else begin
            m_since++;
            if (m_since == TMO) begin m_rec = '0; m_cnt = 0; m_st = ST_IDLE; end
          end
        end
        ST_CHECK: begin
          if (m_rec == code_ref) begin
            m_fails = 0; m_st = ST_UNLOCK;
          end else begin
            m_fail = 1; m_fails++; m_rec = '0; m_cnt = 0; m_lock = 0;
            m_st = (m_fails >= MAXF) ? ST_LOCKOUT : ST_IDLE;
          end
        end
        ST_UNLOCK: if (clear) begin m_rec = '0; m_cnt = 0; m_st = ST_IDLE; end
        ST_LOCKOUT: begin
          m_lock++;
          if (m_lock == LCK) begin m_fails = 0; m_st = ST_IDLE; end
        end
        default: m_st = ST_IDLE;
      endcase
      // each switch: sample delayed two edges, accepted once the last DEB samples agree
      lv_s_prev = lv_s; ok_s_prev = ok_s;
      smp = pipe_s.pop_front(); pipe_s.push_back(sw_strobe);
      hist_s.push_back(smp); if (hist_s.size() > DEB) void'(hist_s.pop_front());
      if (all_same(hist_s)) begin lv_s = smp; ok_s = 1; end
      smp = pipe_d.pop_front(); pipe_d.push_back(sw_data);
      hist_d.push_back(smp); if (hist_d.size() > DEB) void'(hist_d.pop_front());
      if (all_same(hist_d)) begin lv_d = smp; ok_d = 1; end
    end
  end

  always begin
    @(posedge clk);
    #1;
    check("outputs_vs_model",
          {19'd0, state, recorded, bit_count, unlocked, fail, locked_out},
          {19'd0, 3'(m_st), m_rec, 3'(m_cnt), m_st == ST_UNLOCK, m_fail, m_st == ST_LOCKOUT});
    if (fail === 1'b1) fail_seen++;
    if (locked_out === 1'b1) lock_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sw_data = b; sw_strobe = 1'b1;
    tick(10);
    sw_strobe = 1'b0;
    tick(10);
  endtask

  initial begin
    int f0, l0;
    bit found;

    tick(3);
    check("reset_outputs", {state, recorded, bit_count, unlocked, fail, locked_out}, 13'd0);
    rst_n = 1'b1;
    tick(10);

    sw_strobe = 1'b1; tick(2); sw_strobe = 1'b0; tick(10);
    check("glitch_bit_count", bit_count, 0);
    check("glitch_state", state, 0);

    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    check("code_recorded", recorded, 4'b1011);
    check("code_unlocked", unlocked, 1);
    check("code_state", state, 3);
    clear = 1'b1; tick(1); clear = 1'b0; tick(1);
    check("clear_state", state, 0);
    check("clear_recorded", recorded, 0);

    f0 = fail_seen; l0 = lock_seen;
    repeat (3) begin
      send_bit(0); send_bit(0); send_bit(0); send_bit(0);
    end
    check("lockout_entered", locked_out, 1);
    send_bit(1);
    check("lockout_ignores_bits", bit_count, 0);
    tick(20);
    check("lockout_fail_pulses", fail_seen - f0, 3);
    check("lockout_cycles", lock_seen - l0, 40);
    check("lockout_exit_state", state, 0);

    f0 = fail_seen;
    send_bit(1); send_bit(0);
    check("timeout_two_bits", bit_count, 2);
    tick(50);
    check("timeout_bit_count", bit_count, 0);
    check("timeout_state", state, 0);
    check("timeout_no_fail", fail_seen - f0, 0);

    send_bit(1); send_bit(0); send_bit(1);
    sw_data = 1'b1; sw_strobe = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m_pend) begin clear = 1'b1; found = 1; end
    end
    if (!found) check("clear_event_wait_expired", 0, 1);
    tick(1); clear = 1'b0; sw_strobe = 1'b0;
    tick(10);
    check("clear_coincident_state", state, 0);
    check("clear_coincident_count", bit_count, 0);
    check("clear_coincident_no_fail", fail_seen - f0, 0);

    repeat (3) begin
      send_bit(0); send_bit(0); send_bit(0); send_bit(0);
    end
    check("relock_entered", locked_out, 1);
    sw_strobe = 1'b1; tick(3);
    rst_n = 1'b0; tick(2);
    check("reset_mid_lockout", {state, recorded, bit_count, unlocked, fail, locked_out}, 13'd0);
    rst_n = 1'b1;
    tick(30);
    check("held_strobe_no_event", bit_count, 0);
    check("held_strobe_state", state, 0);
    sw_strobe = 1'b0; tick(10);
    sw_data = 1'b1; sw_strobe = 1'b1; tick(10);
    sw_strobe = 1'b0; tick(5);
    check("recycled_strobe_count", bit_count, 1);
    check("recycled_strobe_recorded", recorded, 4'b0001);
    check("recycled_strobe_state", state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
